// File: rtl/local_mean.sv
// rtl/local_mean.sv - per-pixel (2R+1)x(2R+1) window mean written to threshold memory, one pass after reset
// Optional macro LOCAL_MEAN_ROUND_EN: round-to-nearest mean instead of floor mean.
module local_mean #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int WIDTH       = 2**WIDTH_BITS,
  parameter int HEIGHT      = 2**HEIGHT_BITS,
  parameter int R           = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oThresholdCol,
  output logic [HEIGHT_BITS-1:0] oThresholdRow,
  output logic [7:0]             oThresholdData,
  output logic                   oThresholdWren,
  output logic                   finished
);

  localparam int SIDE     = 2*R + 1;
  localparam int N        = SIDE*SIDE;
  localparam int SUM_BITS = 8 + $clog2(N);
  localparam int REM_BITS = $clog2(N) + 1;
  localparam int CNT_BITS = $clog2(N + 1);
  localparam int WIN_BITS = $clog2(SIDE + 1);
  localparam int DIV_BITS = $clog2(SUM_BITS);
  localparam int CW       = WIDTH_BITS + 2;
  localparam int RW       = HEIGHT_BITS + 2;

  localparam logic signed [CW-1:0] COL_MAX  = CW'(WIDTH - 1);
  localparam logic signed [RW-1:0] ROW_MAX  = RW'(HEIGHT - 1);
  localparam logic [WIDTH_BITS-1:0]  COL_LAST = WIDTH_BITS'(WIDTH - 1);
  localparam logic [HEIGHT_BITS-1:0] ROW_LAST = HEIGHT_BITS'(HEIGHT - 1);
  localparam logic [WIN_BITS-1:0]    WIN_LAST = WIN_BITS'(2*R);

`ifdef LOCAL_MEAN_ROUND_EN
  localparam logic [SUM_BITS:0] ROUND_ADD = (SUM_BITS+1)'(N/2);
`else
  localparam logic [SUM_BITS:0] ROUND_ADD = '0;
`endif

  typedef enum logic [1:0] {S_SCAN, S_DIVIDE, S_WRITE, S_DONE} state_t;

  state_t state, state_next;

  logic [WIDTH_BITS-1:0]  cx;
  logic [HEIGHT_BITS-1:0] cy;
  logic [CNT_BITS-1:0]    scan_cnt;
  logic [WIN_BITS-1:0]    win_x, win_y;
  logic [SUM_BITS-1:0]    acc;
  logic [SUM_BITS-1:0]    dvd;
  logic                   ovf;
  logic [REM_BITS-1:0]    rem;
  logic [DIV_BITS-1:0]    div_cnt;

  logic                   scan_last, div_last, last_px;
  logic [SUM_BITS:0]      sum_wide;
  logic [REM_BITS:0]      shifted, diff;
  logic signed [CW-1:0]   col_s;
  logic signed [RW-1:0]   row_s;

  assign scan_last = (scan_cnt == CNT_BITS'(N));
  assign div_last  = (div_cnt == DIV_BITS'(SUM_BITS - 1));
  assign last_px   = (cx == COL_LAST) && (cy == ROW_LAST);

  // Final sample arrives in the last SCAN cycle, so the dividend includes it directly.
  assign sum_wide = {1'b0, acc} + (SUM_BITS+1)'(iImageData) + ROUND_ADD;

  // Restoring divider step: borrow out of the trial subtraction decides the quotient bit.
  assign shifted = {rem, dvd[SUM_BITS-1]};
  assign diff    = shifted - (REM_BITS+1)'(N);

  assign col_s = signed'({2'b00, cx}) + signed'(CW'(win_x)) - signed'(CW'(R));
  assign row_s = signed'({2'b00, cy}) + signed'(RW'(win_y)) - signed'(RW'(R));

  always_comb begin
    oImageCol = col_s[WIDTH_BITS-1:0];
    if (col_s < 0)            oImageCol = '0;
    else if (col_s > COL_MAX) oImageCol = COL_LAST;
    oImageRow = row_s[HEIGHT_BITS-1:0];
    if (row_s < 0)            oImageRow = '0;
    else if (row_s > ROW_MAX) oImageRow = ROW_LAST;
  end

  assign oThresholdCol  = cx;
  assign oThresholdRow  = cy;
  assign oThresholdData = (ovf || (|dvd[SUM_BITS-1:8])) ? 8'hFF : dvd[7:0];

  always_ff @(posedge clock) begin
    if (!reset) state <= S_SCAN;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    oThresholdWren = 1'b0;
    finished       = 1'b0;
    case (state)
      S_SCAN:   if (scan_last) state_next = S_DIVIDE;
      S_DIVIDE: if (div_last) state_next = S_WRITE;
      S_WRITE: begin
        oThresholdWren = 1'b1;
        state_next     = last_px ? S_DONE : S_SCAN;
      end
      S_DONE:   finished = 1'b1;
      default:  state_next = S_SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cx       <= '0;
      cy       <= '0;
      scan_cnt <= '0;
      win_x    <= '0;
      win_y    <= '0;
      acc      <= '0;
      dvd      <= '0;
      ovf      <= 1'b0;
      rem      <= '0;
      div_cnt  <= '0;
    end else begin
      case (state)
        S_SCAN: begin
          if (scan_cnt != '0) acc <= acc + SUM_BITS'(iImageData);
          if (scan_last) begin
            scan_cnt <= '0;
            dvd      <= sum_wide[SUM_BITS-1:0];
            ovf      <= sum_wide[SUM_BITS];
            rem      <= '0;
            div_cnt  <= '0;
          end else begin
            scan_cnt <= scan_cnt + CNT_BITS'(1);
            if (win_x == WIN_LAST) begin
              win_x <= '0;
              win_y <= (win_y == WIN_LAST) ? '0 : win_y + WIN_BITS'(1);
            end else begin
              win_x <= win_x + WIN_BITS'(1);
            end
          end
        end
        S_DIVIDE: begin
          rem     <= diff[REM_BITS] ? shifted[REM_BITS-1:0] : diff[REM_BITS-1:0];
          dvd     <= {dvd[SUM_BITS-2:0], ~diff[REM_BITS]};
          div_cnt <= div_cnt + DIV_BITS'(1);
        end
        S_WRITE: begin
          acc <= '0;
          if (!last_px) begin
            if (cx == COL_LAST) begin
              cx <= '0;
              cy <= cy + HEIGHT_BITS'(1);
            end else begin
              cx <= cx + WIDTH_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_local_mean.sv
// tb/tb_local_mean.sv - self-checking bench for local_mean on an 8x8 image
// Honours LOCAL_MEAN_ROUND_EN when choosing expected means.
module tb_local_mean;

  localparam int WB = 3, HB = 3, W = 8, H = 8, R = 1, N = 9, P = 23, NPIX = 64;
  localparam int RUN_CYCLES = 1600;
`ifdef LOCAL_MEAN_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [WB-1:0] oImageCol, oThresholdCol;
  logic [HB-1:0] oImageRow, oThresholdRow;
  logic [7:0]    iImageData, oThresholdData;
  logic          oThresholdWren, finished;

  logic [7:0] img [NPIX];
  int got [NPIX];
  int wr_cnt [NPIX];
  int n_total = 0, n_pass = 0;
  int nwrites, first_wr, fin_cyc, first_col, first_row;
  bit late_wr, fin_drop, wr_in_rst;

  typedef struct {
    int ix, iy, iv;
    int px, py;
    int exp_fl, exp_rd;
  } vec_t;
  vec_t tbl [14];

  always #5 clock = ~clock;

  always @(posedge clock) iImageData <= img[int'(oImageRow)*W + int'(oImageCol)];

  local_mean #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .R(R)) dut (
    .clock(clock), .reset(reset),
    .oImageCol(oImageCol), .oImageRow(oImageRow), .iImageData(iImageData),
    .oThresholdCol(oThresholdCol), .oThresholdRow(oThresholdRow),
    .oThresholdData(oThresholdData), .oThresholdWren(oThresholdWren),
    .finished(finished)
  );

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int model_mean(int x, int y);
    int s = 0;
    for (int dy = -R; dy <= R; dy++)
      for (int dx = -R; dx <= R; dx++)
        s += int'(img[clampi(y+dy, 0, H-1)*W + clampi(x+dx, 0, W-1)]);
    if (ROUND) s += N/2;
    s = s / N;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic sample(input int cyc);
    int idx;
    if (oThresholdWren) begin
      idx = int'(oThresholdRow)*W + int'(oThresholdCol);
      if (fin_cyc >= 0) late_wr = 1'b1;
      got[idx] = int'(oThresholdData);
      wr_cnt[idx]++;
      if (first_wr < 0) begin
        first_wr  = cyc;
        first_col = int'(oThresholdCol);
        first_row = int'(oThresholdRow);
      end
      nwrites++;
    end
    if (finished && fin_cyc < 0) fin_cyc = cyc;
    else if (!finished && fin_cyc >= 0) fin_drop = 1'b1;
  endtask

  task automatic run_image(input string tag, input int rst_at);
    int cyc;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk({tag, "_rst_wren"}, int'(oThresholdWren), 0);
    chk({tag, "_rst_finished"}, int'(finished), 0);
    chk({tag, "_rst_imgaddr"}, int'({oImageRow, oImageCol}), 0);
    chk({tag, "_rst_thraddr"}, int'({oThresholdRow, oThresholdCol}), 0);
    chk({tag, "_rst_data"}, int'(oThresholdData), 0);
    reset = 1'b1;
    cyc = 0;
    if (rst_at >= 0) begin
      while (cyc < rst_at) begin
        @(posedge clock); @(negedge clock); cyc++;
      end
      reset = 1'b0;
      wr_in_rst = 1'b0;
      repeat (3) begin
        @(posedge clock); @(negedge clock); cyc++;
        if (oThresholdWren) wr_in_rst = 1'b1;
      end
      chk({tag, "_wren_during_reset"}, int'(wr_in_rst), 0);
      reset = 1'b1;
      cyc = 0;
    end
    nwrites = 0; first_wr = -1; fin_cyc = -1; late_wr = 1'b0; fin_drop = 1'b0;
    first_col = -1; first_row = -1;
    for (int i = 0; i < NPIX; i++) begin
      got[i] = -1;
      wr_cnt[i] = 0;
    end
    while (cyc < RUN_CYCLES) begin
      sample(cyc);
      @(posedge clock); @(negedge clock); cyc++;
    end
  endtask

  task automatic check_run(input string tag);
    int bad_cnt = 0;
    chk({tag, "_nwrites"}, nwrites, NPIX);
    chk({tag, "_first_wr_cycle"}, first_wr, P - 1);
    chk({tag, "_first_wr_addr"}, first_row*W + first_col, 0);
    chk({tag, "_finished_cycle"}, fin_cyc, NPIX*P);
    chk({tag, "_wren_after_finished"}, int'(late_wr), 0);
    chk({tag, "_finished_dropped"}, int'(fin_drop), 0);
    for (int i = 0; i < NPIX; i++) if (wr_cnt[i] != 1) bad_cnt++;
    chk({tag, "_pixels_not_written_once"}, bad_cnt, 0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        chk($sformatf("%s_px_%0d_%0d", tag, x, y), got[y*W + x], model_mean(x, y));
  endtask

  initial begin
    int last_key;
    int key;

    tbl[0]  = '{4, 4, 255, 3, 3, 28, 28};
    tbl[1]  = '{4, 4, 255, 5, 5, 28, 28};
    tbl[2]  = '{4, 4, 255, 4, 4, 28, 28};
    tbl[3]  = '{4, 4, 255, 2, 4, 0, 0};
    tbl[4]  = '{4, 4, 255, 6, 6, 0, 0};
    tbl[5]  = '{0, 0, 90, 0, 0, 40, 40};
    tbl[6]  = '{0, 0, 90, 1, 0, 20, 20};
    tbl[7]  = '{0, 0, 90, 0, 1, 20, 20};
    tbl[8]  = '{0, 0, 90, 1, 1, 10, 10};
    tbl[9]  = '{0, 0, 90, 2, 0, 0, 0};
    tbl[10] = '{0, 0, 90, 0, 2, 0, 0};
    tbl[11] = '{4, 4, 5, 4, 4, 0, 1};
    tbl[12] = '{4, 4, 5, 3, 5, 0, 1};
    tbl[13] = '{4, 4, 5, 2, 2, 0, 0};

    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    run_image("const100", -1);
    check_run("const100");
    chk("const100_first_px", got[0], 100);
    chk("const100_last_px", got[NPIX-1], 100);

    last_key = -1;
    for (int i = 0; i < 14; i++) begin
      key = (tbl[i].iy*W + tbl[i].ix)*256 + tbl[i].iv;
      if (key != last_key) begin
        for (int j = 0; j < NPIX; j++) img[j] = 8'd0;
        img[tbl[i].iy*W + tbl[i].ix] = 8'(tbl[i].iv);
        run_image($sformatf("imp%0d", tbl[i].iv), -1);
        check_run($sformatf("imp%0d", tbl[i].iv));
        last_key = key;
      end
      chk($sformatf("vec%0d_px_%0d_%0d", i, tbl[i].px, tbl[i].py),
          got[tbl[i].py*W + tbl[i].px], ROUND ? tbl[i].exp_rd : tbl[i].exp_fl);
    end

    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255, 0));
    run_image("rand_full", -1);
    check_run("rand_full");

    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255, 250));
    run_image("rand_high", -1);
    check_run("rand_high");

    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255, 0));
    run_image("mid_reset", 50);
    check_run("mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
